// File: rtl/copro_fdiv_seq.sv
// LM32 user-instruction coprocessor: single-cycle float multiply and a sequential restoring float divide.
// Results truncate rather than round; zero operands and exponent over/underflow saturate.
package float_pack;
   localparam int Nm   = 23;
   localparam int Ne   = 8;
   localparam int W    = 1 + Ne + Nm;
   localparam int BIAS = 2**(Ne-1) - 1;

   function automatic logic [W-1:0] float_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic             s;
      int               e;
      logic [2*Nm+1:0]  ma, mb, p;
      logic [Nm-1:0]    m;
      s  = a[W-1] ^ b[W-1];
      e  = int'(a[W-2:Nm]) + int'(b[W-2:Nm]) - BIAS;
      ma = {{(Nm+1){1'b0}}, 1'b1, a[Nm-1:0]};
      mb = {{(Nm+1){1'b0}}, 1'b1, b[Nm-1:0]};
      p  = ma * mb;
      if (p[2*Nm+1]) begin
         m = p[2*Nm:Nm+1];
         e = e + 1;
      end else begin
         m = p[2*Nm-1:Nm];
      end
      if (a[W-2:0] == '0 || b[W-2:0] == '0 || e <= 0) return {s, {(W-1){1'b0}}};
      if (e >= 2**Ne - 1) return {s, {Ne{1'b1}}, {Nm{1'b0}}};
      return {s, e[Ne-1:0], m};
   endfunction

   function automatic logic [W-1:0] float_div(input logic [W-1:0] a, input logic [W-1:0] b);
      logic             s;
      int               e;
      logic [2*Nm+1:0]  ma, mb, q;
      logic [Nm-1:0]    m;
      s = a[W-1] ^ b[W-1];
      e = int'(a[W-2:Nm]) - int'(b[W-2:Nm]) + BIAS;
      if (e < 0 || a[W-2:0] == '0) return {s, {(W-1){1'b0}}};
      if (b[W-2:0] == '0) return {s, {Ne{1'b1}}, {Nm{1'b0}}};
      ma = {{(Nm+1){1'b0}}, 1'b1, a[Nm-1:0]};
      mb = {{(Nm+1){1'b0}}, 1'b1, b[Nm-1:0]};
      q  = (ma << Nm) / mb;
      if (q[Nm]) begin
         m = q[Nm-1:0];
      end else begin
         m = {q[Nm-2:0], 1'b0};
         e = e - 1;
      end
      if (e <= 0) return {s, {(W-1){1'b0}}};
      if (e >= 2**Ne - 1) return {s, {Ne{1'b1}}, {Nm{1'b0}}};
      return {s, e[Ne-1:0], m};
   endfunction
endpackage

// state | meaning
// IDLE  | waiting for copro_valid_i; operands captured on acceptance
// EXEC  | mul / illegal / div special cases resolved; otherwise divider loaded
// DIV   | one restoring quotient bit per cycle, MSB first, Nm+1 cycles
// NORM  | normalise quotient, saturate exponent
// DONE  | one-cycle completion pulse
module copro_fdiv_seq #(
   parameter int Nm = float_pack::Nm,
   parameter int Ne = float_pack::Ne
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        copro_valid_i,
   input  logic [2:0]  copro_opcode_i,
   input  logic [31:0] copro_op0_i,
   input  logic [31:0] copro_op1_i,
   output logic        copro_complete_o,
   output logic [31:0] copro_result_o,
   output logic        busy_o,
   output logic        illegal_o
);
   localparam int W  = 1 + Ne + Nm;
   localparam int EW = Ne + 2;
   localparam int CW = $clog2(Nm + 1);
   localparam logic signed [EW-1:0] BIAS    = EW'(2**(Ne-1) - 1);
   localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DIV, S_NORM, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [W-1:0]          a_q, a_d, b_q, b_d;
   logic                  sign_q, sign_d;
   logic signed [EW-1:0]  exp_q, exp_d;
   logic [Nm+1:0]         rem_q, rem_d;
   logic [Nm:0]           quo_q, quo_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [W-1:0]          res_q, res_d;
   logic                  ill_q, ill_d;

   logic                  sign_c, a_zero, b_zero, ge;
   logic signed [EW-1:0]  exp_calc, exp_n;
   logic [Nm+1:0]         dvs, diff;
   logic [Nm-1:0]         mant;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      ill_d    = ill_q;

      sign_c   = a_q[W-1] ^ b_q[W-1];
      a_zero   = (a_q[W-2:0] == '0);
      b_zero   = (b_q[W-2:0] == '0);
      exp_calc = $signed({2'b00, a_q[W-2:Nm]}) - $signed({2'b00, b_q[W-2:Nm]}) + BIAS;
      dvs      = {1'b0, 1'b1, b_q[Nm-1:0]};
      ge       = (rem_q >= dvs);
      diff     = ge ? (rem_q - dvs) : rem_q;
      exp_n    = exp_q;
      mant     = quo_q[Nm-1:0];

      case (state_q)
         S_IDLE: begin
            if (copro_valid_i) begin
               op_d    = copro_opcode_i;
               a_d     = copro_op0_i[W-1:0];
               b_d     = copro_op1_i[W-1:0];
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            ill_d   = 1'b0;
            state_d = S_DONE;
            if (op_q == 3'd0) begin
               res_d = float_pack::float_mul(a_q, b_q);
            end else if (op_q == 3'd1) begin
               sign_d = sign_c;
               exp_d  = exp_calc;
               if (exp_calc[EW-1] || a_zero) begin
                  res_d = {sign_c, {(W-1){1'b0}}};
               end else if (b_zero) begin
                  res_d = {sign_c, {Ne{1'b1}}, {Nm{1'b0}}};
               end else begin
                  rem_d   = {1'b0, 1'b1, a_q[Nm-1:0]};
                  quo_d   = '0;
                  cnt_d   = '0;
                  state_d = S_DIV;
               end
            end else begin
               res_d = '0;
               ill_d = 1'b1;
            end
         end
         S_DIV: begin
            // remainder stays below twice the divisor, so the shift never loses a set bit
            rem_d = {diff[Nm:0], 1'b0};
            quo_d = {quo_q[Nm-1:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(Nm)) state_d = S_NORM;
         end
         S_NORM: begin
            if (!quo_q[Nm]) begin
               mant  = {quo_q[Nm-2:0], 1'b0};
               exp_n = exp_q - EXP_ONE;
            end
            exp_d   = exp_n;
            state_d = S_DONE;
            if (exp_n[EW-1]) begin
               res_d = {sign_q, {(W-1){1'b0}}};
            end else if (exp_n[Ne] || (&exp_n[Ne-1:0])) begin
               res_d = {sign_q, {Ne{1'b1}}, {Nm{1'b0}}};
            end else if (exp_n == '0) begin
               res_d = {sign_q, {(W-1){1'b0}}};
            end else begin
               res_d = {sign_q, exp_n[Ne-1:0], mant};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign copro_complete_o = (state_q == S_DONE);
   assign illegal_o        = (state_q == S_DONE) && ill_q;
   assign busy_o           = (state_q != S_IDLE);
   assign copro_result_o   = 32'(res_q);
endmodule

// File: tb/tb_copro_fdiv_seq.sv
// Self-checking bench for copro_fdiv_seq: directed vectors, protocol corner cases and random operands
// compared against an integer-arithmetic model of truncating single-precision mul/div.
module tb_copro_fdiv_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [2:0]  opcode;
   logic [31:0] op0, op1;
   logic        complete, busy, illegal;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   copro_fdiv_seq dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .copro_valid_i    (valid),
      .copro_opcode_i   (opcode),
      .copro_op0_i      (op0),
      .copro_op1_i      (op1),
      .copro_complete_o (complete),
      .copro_result_o   (result),
      .busy_o           (busy),
      .illegal_o        (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int e;
      longint ma, mb, p;
      logic [22:0] m;
      s  = a[31] ^ b[31];
      e  = int'(a[30:23]) + int'(b[30:23]) - 127;
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      p  = ma * mb;
      if (p >= (longint'(1) << 47)) begin
         m = 23'(p >> 24);
         e = e + 1;
      end else begin
         m = 23'(p >> 23);
      end
      if (a[30:0] == 0 || b[30:0] == 0 || e <= 0) return {s, 31'd0};
      if (e >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(e), m};
   endfunction

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int e;
      longint ma, mb, q;
      logic [22:0] m;
      s = a[31] ^ b[31];
      e = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (e < 0 || a[30:0] == 0) return {s, 31'd0};
      if (b[30:0] == 0) return {s, 8'hFF, 23'd0};
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      q  = (ma << 23) / mb;
      if (q >= (longint'(1) << 23)) begin
         m = 23'(q - (longint'(1) << 23));
      end else begin
         m = 23'(2 * q - (longint'(1) << 23));
         e = e - 1;
      end
      if (e <= 0) return {s, 31'd0};
      if (e >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(e), m};
   endfunction

   function automatic bit div_is_special(input logic [31:0] a, input logic [31:0] b);
      int e;
      e = int'(a[30:23]) - int'(b[30:23]) + 127;
      return (e < 0) || (a[30:0] == 0) || (b[30:0] == 0);
   endfunction

   function automatic logic [31:0] rand_float();
      int unsigned r;
      logic [31:0] v;
      r = $urandom_range(0, 9);
      v = $urandom;
      if (r == 0) return {v[31], 31'd0};
      if (r < 4) return v;
      return {v[31], 8'($urandom_range(100, 154)), v[22:0]};
   endfunction

   // Waits for the DUT to be idle, then presents one command for exactly one sampling edge.
   task automatic drive_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         @(posedge clk);
         #1;
      end
      valid  = 1'b1;
      opcode = op;
      op0    = a;
      op1    = b;
      @(posedge clk);
      #1;
      valid  = 1'b0;
   endtask

   // lat counts cycles from the sampling cycle (cycle 0); -1 when no completion arrives.
   task automatic wait_done(output int lat, output logic [31:0] res, output logic ill);
      int cyc;
      cyc = 1;
      lat = -1;
      res = 'x;
      ill = 1'bx;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (complete) begin
            lat = cyc;
            res = result;
            ill = illegal;
            break;
         end
      end
   endtask

   task automatic test_reset();
      valid = 1'b0; opcode = '0; op0 = '0; op1 = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({complete, busy, illegal, result} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs: complete=%b busy=%b illegal=%b result=%h, required all zero",
                  complete, busy, illegal, result);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_mul_basic();
      int lat; logic [31:0] res; logic ill;
      drive_cmd(3'd0, 32'h40000000, 32'h40400000);
      wait_done(lat, res, ill);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL mul_latency: got %0d required 2", lat); end
      checks++;
      if (res !== 32'h40C00000) begin errors++; $display("FAIL mul_result: got %h required 40c00000", res); end
      checks++;
      if (ill !== 1'b0) begin errors++; $display("FAIL mul_illegal: got %b required 0", ill); end
      @(posedge clk);
      #1;
      checks++;
      if (complete !== 1'b0 || result !== 32'h40C00000) begin
         errors++;
         $display("FAIL mul_pulse_hold: complete=%b result=%h required 0 / 40c00000", complete, result);
      end
   endtask

   task automatic test_div_basic();
      int lat; logic [31:0] res; logic ill;
      drive_cmd(3'd1, 32'h40C00000, 32'h40000000);
      wait_done(lat, res, ill);
      checks++;
      if (lat !== 27) begin errors++; $display("FAIL div_latency: got %0d required 27", lat); end
      checks++;
      if (res !== 32'h40400000) begin errors++; $display("FAIL div_6_2: got %h required 40400000", res); end
      drive_cmd(3'd1, 32'h3F800000, 32'h40000000);
      wait_done(lat, res, ill);
      checks++;
      if (res !== 32'h3F000000 || lat !== 27) begin
         errors++;
         $display("FAIL div_1_2: got %h lat %0d required 3f000000 lat 27", res, lat);
      end
   endtask

   task automatic test_div_norm_path();
      int lat; logic [31:0] res; logic ill;
      drive_cmd(3'd1, 32'h3F800000, 32'h3FC00000);
      wait_done(lat, res, ill);
      checks++;
      if (res !== ref_div(32'h3F800000, 32'h3FC00000) || res !== 32'h3F2AAAAA) begin
         errors++;
         $display("FAIL div_norm: got %h required %h", res, ref_div(32'h3F800000, 32'h3FC00000));
      end
      checks++;
      if (res[30:23] !== 8'h7E) begin errors++; $display("FAIL div_norm_exp: got %h required 7e", res[30:23]); end
   endtask

   task automatic test_div_special();
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic [31:0] vr [3];
      int lat; logic [31:0] res; logic ill;
      va = '{32'h3F800000, 32'h00000000, 32'h80000000};
      vb = '{32'h00000000, 32'h00000000, 32'h3F800000};
      vr = '{32'h7F800000, 32'h00000000, 32'h80000000};
      for (int i = 0; i < 3; i++) begin
         drive_cmd(3'd1, va[i], vb[i]);
         wait_done(lat, res, ill);
         checks++;
         if (res !== vr[i] || lat !== 2) begin
            errors++;
            $display("FAIL div_special_%0d: got %h lat %0d required %h lat 2", i, res, lat, vr[i]);
         end
      end
   endtask

   task automatic test_illegal();
      int lat; logic [31:0] res; logic ill;
      drive_cmd(3'd0, 32'h40000000, 32'h40400000);
      wait_done(lat, res, ill);
      for (int op = 2; op < 8; op++) begin
         drive_cmd(3'(op), 32'h40000000, 32'h40400000);
         wait_done(lat, res, ill);
         checks++;
         if (res !== 32'd0 || ill !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL illegal_op%0d: result %h illegal %b lat %0d required 0 / 1 / 2", op, res, ill, lat);
         end
         @(posedge clk);
         #1;
         checks++;
         if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse_op%0d: illegal=%b required 0", op, illegal); end
      end
   endtask

   task automatic test_busy_ignore();
      int cyc, ncomp, first_lat;
      logic [31:0] first_res;
      logic busy_mid;
      drive_cmd(3'd1, 32'h40C00000, 32'h40000000);
      cyc = 1; ncomp = 0; first_lat = -1; first_res = '0; busy_mid = 1'b0;
      for (int i = 0; i < 45; i++) begin
         if (cyc < 20) begin
            valid = 1'b1; opcode = 3'd0; op0 = $urandom; op1 = $urandom;
         end else begin
            valid = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 10) busy_mid = busy;
         if (complete) begin
            ncomp++;
            if (first_lat < 0) begin first_lat = cyc; first_res = result; end
         end
      end
      valid = 1'b0;
      checks++;
      if (busy_mid !== 1'b1) begin errors++; $display("FAIL busy_high: got %b required 1", busy_mid); end
      checks++;
      if (ncomp !== 1 || first_lat !== 27) begin
         errors++;
         $display("FAIL busy_ignore: completions %0d first at %0d required 1 at 27", ncomp, first_lat);
      end
      checks++;
      if (first_res !== 32'h40400000) begin errors++; $display("FAIL busy_ignore_result: got %h required 40400000", first_res); end
   endtask

   task automatic test_reset_mid_op();
      int lat, ncomp; logic [31:0] res; logic ill;
      drive_cmd(3'd1, 32'h40C00000, 32'h40000000);
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checks++;
      if ({complete, busy, illegal, result} !== 35'd0) begin
         errors++;
         $display("FAIL reset_mid: complete=%b busy=%b illegal=%b result=%h required all zero",
                  complete, busy, illegal, result);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      ncomp = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (complete) ncomp++;
      end
      checks++;
      if (ncomp !== 0) begin errors++; $display("FAIL reset_abort: completions %0d required 0", ncomp); end
      drive_cmd(3'd0, 32'h40000000, 32'h40400000);
      wait_done(lat, res, ill);
      checks++;
      if (lat !== 2 || res !== 32'h40C00000) begin
         errors++;
         $display("FAIL reset_recover: lat %0d result %h required 2 / 40c00000", lat, res);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] res; logic ill;
      drive_cmd(3'd0, 32'h3F800000, 32'h40000000);
      wait_done(lat, res, ill);
      valid = 1'b1; opcode = 3'd1; op0 = 32'h40C00000; op1 = 32'h40000000;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b required 0", busy); end
      @(posedge clk);
      #1;
      valid = 1'b0;
      wait_done(lat, res, ill);
      checks++;
      if (lat !== 27 || res !== 32'h40400000) begin
         errors++;
         $display("FAIL b2b_div: lat %0d result %h required 27 / 40400000", lat, res);
      end
   endtask

   task automatic test_random();
      int lat, exp_lat; logic [31:0] res, a, b, exp_res; logic ill;
      logic [2:0] op;
      for (int n = 0; n < 2000; n++) begin
         op = 3'($urandom_range(0, 1));
         a  = rand_float();
         b  = rand_float();
         if (op == 3'd0) begin
            exp_res = ref_mul(a, b);
            exp_lat = 2;
         end else begin
            exp_res = ref_div(a, b);
            exp_lat = div_is_special(a, b) ? 2 : 27;
         end
         drive_cmd(op, a, b);
         wait_done(lat, res, ill);
         checks++;
         if (res !== exp_res || lat !== exp_lat || ill !== 1'b0) begin
            errors++;
            $display("FAIL random op%0d %h,%h: result %h lat %0d illegal %b required %h lat %0d illegal 0",
                     op, a, b, res, lat, ill, exp_res, exp_lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_div_basic();
      test_div_norm_path();
      test_div_special();
      test_illegal();
      test_busy_ignore();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
